// File: rtl/microcode_pkg.sv
// Shared types and constants for the microcode expander: widths, opcodes, the uop word
// layout (opclass[15:12], operand[11:3], LAST[2], reserved[1:0]) and the FSM state enum.
package microcode_pkg;

    localparam int PC_W     = 8;
    localparam int UW       = 16;
    localparam int MAX_UOPS = 4;
    localparam int ROM_AW   = 4;
    localparam int LAST_BIT = 2;

    localparam logic [PC_W-1:0] RESET_PC = 8'h00;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    localparam logic [3:0] CLS_ALU  = 4'h1;
    localparam logic [3:0] CLS_AGU  = 4'h2;
    localparam logic [3:0] CLS_LD   = 4'h3;
    localparam logic [3:0] CLS_ST   = 4'h4;
    localparam logic [3:0] CLS_BR   = 4'h5;
    localparam logic [3:0] CLS_WB   = 4'h6;
    localparam logic [3:0] CLS_TRAP = 4'hF;

    localparam logic [UW-1:0] TRAP_WORD = {CLS_TRAP, 9'h1FF, 1'b1, 2'b00};

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_EXPAND
    } exp_state_e;

    // lastIdx holds (length - 1), so the 2-bit field covers 1..MAX_UOPS words.
    typedef struct packed {
        logic [1:0]        lastIdx;
        logic [ROM_AW-1:0] base;
    } decode_t;

    function automatic logic [UW-1:0] mk_uop(input logic [3:0] cls, input logic [8:0] operand,
                                             input logic last);
        return {cls, operand, last, 2'b00};
    endfunction

endpackage

// File: rtl/microcode_expander_if.sv
// Bundles the instruction-fetch bus, the microcode stream and the redirect/busy side-band of the
// expander; master is the expander, slave is its environment (memory, buffer, execute).
interface microcode_expander_if;
    import microcode_pkg::*;

    logic            mem_req;
    logic [PC_W-1:0] mem_addr;
    logic            mem_ack;
    logic [31:0]     mem_rdata;
    logic            uop_valid;
    logic            uop_ready;
    logic [UW-1:0]   uop_data;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            busy;

    modport master (
        output mem_req, mem_addr, uop_valid, uop_data, busy,
        input  mem_ack, mem_rdata, uop_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, uop_valid, uop_data, busy,
        output mem_ack, mem_rdata, uop_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/microcode_rom.sv
// Combinational microcode ROM: {opcode, funct3} decodes to {length, base}, and a word address
// returns the stored microcode word. Anything not recognised maps to the single TRAP word.
module microcode_rom
    import microcode_pkg::*;
(
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    output decode_t           decode_o,
    input  logic [ROM_AW-1:0] addr_i,
    output logic [UW-1:0]     word_o
);

    always_comb begin
        decode_o = '{lastIdx: 2'd0, base: 4'd11};
        case (opcode_i)
            OPC_OP:     if (funct3_i == 3'd0) decode_o = '{lastIdx: 2'd0, base: 4'd0};
            OPC_LOAD:   if (funct3_i == 3'd2) decode_o = '{lastIdx: 2'd2, base: 4'd1};
            OPC_STORE:  if (funct3_i == 3'd2) decode_o = '{lastIdx: 2'd1, base: 4'd4};
            OPC_OPIMM:  if (funct3_i == 3'd0) decode_o = '{lastIdx: 2'd0, base: 4'd6};
            OPC_JAL:    decode_o = '{lastIdx: 2'd1, base: 4'd7};
            OPC_BRANCH: if (funct3_i == 3'd0) decode_o = '{lastIdx: 2'd1, base: 4'd9};
            default:    decode_o = '{lastIdx: 2'd0, base: 4'd11};
        endcase
    end

    // Only the final word of each sequence carries LAST.
    always_comb begin
        word_o = TRAP_WORD;
        case (addr_i)
            4'd0:    word_o = mk_uop(CLS_ALU, 9'h001, 1'b1);
            4'd1:    word_o = mk_uop(CLS_AGU, 9'h002, 1'b0);
            4'd2:    word_o = mk_uop(CLS_LD,  9'h003, 1'b0);
            4'd3:    word_o = mk_uop(CLS_WB,  9'h004, 1'b1);
            4'd4:    word_o = mk_uop(CLS_AGU, 9'h005, 1'b0);
            4'd5:    word_o = mk_uop(CLS_ST,  9'h006, 1'b1);
            4'd6:    word_o = mk_uop(CLS_ALU, 9'h007, 1'b1);
            4'd7:    word_o = mk_uop(CLS_BR,  9'h008, 1'b0);
            4'd8:    word_o = mk_uop(CLS_WB,  9'h009, 1'b1);
            4'd9:    word_o = mk_uop(CLS_ALU, 9'h00A, 1'b0);
            4'd10:   word_o = mk_uop(CLS_BR,  9'h00B, 1'b1);
            default: word_o = TRAP_WORD;
        endcase
    end

endmodule

// File: rtl/microcode_expander.sv
// Fetches instructions, expands each into 1..MAX_UOPS microcode words through microcode_rom and
// streams them out under valid/ready; owns the fetch PC and honours redirects from execute.
module microcode_expander
    import microcode_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    microcode_expander_if.master bus
);

    exp_state_e        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   addr_q, addr_d;
    logic              drop_q, drop_d;
    logic              memReq_q, memReq_d;
    logic              uopValid_q, uopValid_d;
    logic [UW-1:0]     uopData_q, uopData_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        lastIdx_q, lastIdx_d;
    logic [ROM_AW-1:0] base_q, base_d;

    logic [ROM_AW-1:0] romAddr;
    logic [UW-1:0]     romWord;
    logic [PC_W-1:0]   redirTarget;
    decode_t           dec;
    logic              accept;
    logic              unused_rdata;

    microcode_rom u_rom (
        .opcode_i (bus.mem_rdata[6:0]),
        .funct3_i (bus.mem_rdata[14:12]),
        .decode_o (dec),
        .addr_i   (romAddr),
        .word_o   (romWord)
    );

    assign unused_rdata = ^{bus.mem_rdata[31:15], bus.mem_rdata[11:7]};
    assign redirTarget  = {bus.redirect_pc[PC_W-1:2], 2'b00};
    assign accept       = uopValid_q & bus.uop_ready;

    // The word register is loaded one step ahead: decoded base on ack, base+idx+1 on each accept.
    assign romAddr = (state_q == ST_EXPAND) ? base_q + ROM_AW'(idx_q) + ROM_AW'(1) : dec.base;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        drop_d     = drop_q;
        memReq_d   = memReq_q;
        uopValid_d = uopValid_q;
        uopData_d  = uopData_q;
        idx_d      = idx_q;
        lastIdx_d  = lastIdx_q;
        base_d     = base_q;
        case (state_q)
            ST_FETCH: begin
                if (bus.redirect) begin
                    pc_d = redirTarget;
                end else begin
                    memReq_d = 1'b1;
                    addr_d   = pc_q;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mem_ack) begin
                    memReq_d = 1'b0;
                    if (bus.redirect || drop_q) begin
                        if (bus.redirect) pc_d = redirTarget;
                        drop_d  = 1'b0;
                        state_d = ST_FETCH;
                    end else begin
                        lastIdx_d  = dec.lastIdx;
                        base_d     = dec.base;
                        idx_d      = 2'd0;
                        uopValid_d = 1'b1;
                        uopData_d  = romWord;
                        state_d    = ST_EXPAND;
                    end
                end else if (bus.redirect) begin
                    // The memory handshake must complete, so the stale response is dropped later.
                    pc_d   = redirTarget;
                    drop_d = 1'b1;
                end
            end
            ST_EXPAND: begin
                if (bus.redirect) begin
                    uopValid_d = 1'b0;
                    pc_d       = redirTarget;
                    idx_d      = 2'd0;
                    state_d    = ST_FETCH;
                end else if (accept) begin
                    if (idx_q == lastIdx_q) begin
                        uopValid_d = 1'b0;
                        pc_d       = pc_q + PC_W'(4);
                        idx_d      = 2'd0;
                        state_d    = ST_FETCH;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        uopData_d = romWord;
                    end
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            drop_q     <= 1'b0;
            memReq_q   <= 1'b0;
            uopValid_q <= 1'b0;
            uopData_q  <= '0;
            idx_q      <= 2'd0;
            lastIdx_q  <= 2'd0;
            base_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            drop_q     <= drop_d;
            memReq_q   <= memReq_d;
            uopValid_q <= uopValid_d;
            uopData_q  <= uopData_d;
            idx_q      <= idx_d;
            lastIdx_q  <= lastIdx_d;
            base_q     <= base_d;
        end
    end

    assign bus.mem_req   = memReq_q;
    assign bus.mem_addr  = addr_q;
    assign bus.uop_valid = uopValid_q;
    assign bus.uop_data  = uopData_q;
    assign bus.busy      = (state_q != ST_FETCH);

endmodule

// File: tb/tb_microcode_expander.sv
// Bench for microcode_expander: directed scenarios plus a randomized instruction stream, each
// checked against an instruction-level table of expected microcode words.
module tb_microcode_expander;
    import microcode_pkg::*;

    localparam logic [31:0] ADD_I = 32'h002081B3;
    localparam logic [31:0] LW_I  = 32'h0040A183;
    localparam logic [31:0] ILL_I = 32'h0000007F;

    logic       clk;
    logic       rst_n;
    int         checks;
    int         errors;
    logic [7:0] expPc;

    microcode_expander_if bus();

    microcode_expander dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction class: 0 ADD, 1 LW, 2 SW, 3 ADDI, 4 JAL, 5 BEQ, 6 anything else (TRAP).
    function automatic int kind_of(input logic [31:0] i);
        if (i[6:0] == 7'h33 && i[14:12] == 3'd0) return 0;
        if (i[6:0] == 7'h03 && i[14:12] == 3'd2) return 1;
        if (i[6:0] == 7'h23 && i[14:12] == 3'd2) return 2;
        if (i[6:0] == 7'h13 && i[14:12] == 3'd0) return 3;
        if (i[6:0] == 7'h6F)                     return 4;
        if (i[6:0] == 7'h63 && i[14:12] == 3'd0) return 5;
        return 6;
    endfunction

    function automatic int exp_len(input int kind);
        case (kind)
            1:       return 3;
            2, 4, 5: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [15:0] exp_word(input int kind, input int k);
        case (kind)
            0:       return 16'h100C;
            1:       return (k == 0) ? 16'h2010 : (k == 1) ? 16'h3018 : 16'h6024;
            2:       return (k == 0) ? 16'h2028 : 16'h4034;
            3:       return 16'h103C;
            4:       return (k == 0) ? 16'h5040 : 16'h604C;
            5:       return (k == 0) ? 16'h1050 : 16'h505C;
            default: return 16'hFFFC;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: begin r[6:0] = 7'h33; r[14:12] = 3'd0; end
            1: begin r[6:0] = 7'h03; r[14:12] = 3'd2; end
            2: begin r[6:0] = 7'h23; r[14:12] = 3'd2; end
            3: begin r[6:0] = 7'h13; r[14:12] = 3'd0; end
            4: r[6:0] = 7'h6F;
            5: begin r[6:0] = 7'h63; r[14:12] = 3'd0; end
            default: ;
        endcase
        return r;
    endfunction

    task automatic wait_req(input logic [7:0] addr, input string tag);
        int n;
        n = 0;
        while (bus.mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.mem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_req got mem_req=%b want 1", tag, bus.mem_req);
        end
        checks++;
        if (bus.mem_addr !== addr) begin
            errors++;
            $display("[TB] FAIL %s_addr got %h want %h", tag, bus.mem_addr, addr);
        end
    endtask

    task automatic ack_after(input logic [31:0] instr, input int delay, input logic [7:0] addr,
                             input string tag);
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== addr) begin
                errors++;
                $display("[TB] FAIL %s_hold got req=%b addr=%h want req=1 addr=%h",
                         tag, bus.mem_req, bus.mem_addr, addr);
            end
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = instr;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
    endtask

    task automatic collect(input logic [31:0] instr, input int stall, input string tag);
        int kind;
        int n;
        int lastCount;
        kind      = kind_of(instr);
        n         = exp_len(kind);
        lastCount = 0;
        for (int k = 0; k < n; k++) begin
            int w;
            w = 0;
            while (bus.uop_valid !== 1'b1 && w < 8) begin
                @(negedge clk);
                w++;
            end
            for (int s = 0; s < stall; s++) begin
                checks++;
                if (bus.uop_valid !== 1'b1 || bus.uop_data !== exp_word(kind, k)) begin
                    errors++;
                    $display("[TB] FAIL %s_stall%0d got v=%b d=%h want v=1 d=%h",
                             tag, k, bus.uop_valid, bus.uop_data, exp_word(kind, k));
                end
                @(negedge clk);
            end
            checks++;
            if (bus.uop_valid !== 1'b1 || bus.uop_data !== exp_word(kind, k)) begin
                errors++;
                $display("[TB] FAIL %s_word%0d got v=%b d=%h want v=1 d=%h",
                         tag, k, bus.uop_valid, bus.uop_data, exp_word(kind, k));
            end
            if (bus.uop_data[2] === 1'b1) lastCount++;
            bus.uop_ready = 1'b1;
            @(negedge clk);
            bus.uop_ready = 1'b0;
        end
        checks++;
        if (lastCount != 1) begin
            errors++;
            $display("[TB] FAIL %s_lastcount got %0d want 1", tag, lastCount);
        end
        checks++;
        if (bus.uop_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_idle got uop_valid=%b want 0", tag, bus.uop_valid);
        end
    endtask

    task automatic expect_quiet(input int cycles, input string tag);
        for (int c = 0; c < cycles; c++) begin
            checks++;
            if (bus.uop_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s_quiet got uop_valid=%b want 0", tag, bus.uop_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        bus.uop_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.uop_valid !== 1'b0 || bus.uop_data !== 16'h0000 ||
            bus.busy !== 1'b0 || bus.mem_addr !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset got req=%b v=%b d=%h busy=%b addr=%h want 0 0 0000 0 00",
                     bus.mem_req, bus.uop_valid, bus.uop_data, bus.busy, bus.mem_addr);
        end
        expPc = 8'h00;
    endtask

    task automatic test_add();
        wait_req(expPc, "add");
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL add_busy got %b want 1", bus.busy);
        end
        ack_after(ADD_I, 0, expPc, "add");
        collect(ADD_I, 0, "add");
        expPc = expPc + 8'd4;
    endtask

    task automatic test_lw_stall();
        wait_req(expPc, "lw");
        ack_after(LW_I, 1, expPc, "lw");
        collect(LW_I, 2, "lw");
        expPc = expPc + 8'd4;
    endtask

    task automatic test_redirect_expand();
        wait_req(expPc, "rdx");
        ack_after(LW_I, 0, expPc, "rdx");
        checks++;
        if (bus.uop_valid !== 1'b1 || bus.uop_data !== 16'h2010) begin
            errors++;
            $display("[TB] FAIL rdx_w0 got v=%b d=%h want v=1 d=2010", bus.uop_valid, bus.uop_data);
        end
        bus.uop_ready = 1'b1;
        @(negedge clk);
        bus.uop_ready = 1'b0;
        checks++;
        if (bus.uop_valid !== 1'b1 || bus.uop_data !== 16'h3018) begin
            errors++;
            $display("[TB] FAIL rdx_w1 got v=%b d=%h want v=1 d=3018", bus.uop_valid, bus.uop_data);
        end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h41;
        @(negedge clk);
        bus.redirect = 1'b0;
        expect_quiet(3, "rdx");
        expPc = 8'h40;
    endtask

    task automatic test_redirect_wait();
        wait_req(expPc, "rdw");
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h80;
        @(negedge clk);
        bus.redirect = 1'b0;
        ack_after(ADD_I, 2, expPc, "rdw");
        expect_quiet(4, "rdw");
        expPc = 8'h80;
    endtask

    task automatic test_ack_with_redirect();
        wait_req(expPc, "ackr");
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'hFE;
        bus.mem_ack     = 1'b1;
        bus.mem_rdata   = ADD_I;
        @(negedge clk);
        bus.redirect = 1'b0;
        bus.mem_ack  = 1'b0;
        expect_quiet(2, "ackr");
        expPc = 8'hFC;
    endtask

    task automatic test_wrap_and_illegal();
        wait_req(expPc, "wrap");
        ack_after(ADD_I, 0, expPc, "wrap");
        collect(ADD_I, 1, "wrap");
        expPc = expPc + 8'd4;
        wait_req(expPc, "ill");
        ack_after(ILL_I, 0, expPc, "ill");
        collect(ILL_I, 1, "ill");
        expPc = expPc + 8'd4;
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 24; t++) begin
            logic [31:0] instr;
            instr = rand_instr();
            wait_req(expPc, "rnd");
            ack_after(instr, $urandom_range(0, 3), expPc, "rnd");
            collect(instr, $urandom_range(0, 2), "rnd");
            expPc = expPc + 8'd4;
        end
    endtask

    task automatic test_reset_mid_expand();
        wait_req(expPc, "rstm");
        ack_after(LW_I, 0, expPc, "rstm");
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.uop_valid !== 1'b0 || bus.mem_req !== 1'b0 || bus.uop_data !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL rstm_async got v=%b req=%b d=%h want 0 0 0000",
                     bus.uop_valid, bus.mem_req, bus.uop_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        expPc = 8'h00;
        wait_req(expPc, "rstm_after");
        ack_after(ADD_I, 0, expPc, "rstm_after");
        collect(ADD_I, 0, "rstm_after");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_lw_stall();
        test_redirect_expand();
        test_redirect_wait();
        test_ack_with_redirect();
        test_wrap_and_illegal();
        test_back_to_back();
        test_reset_mid_expand();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
